// File: rtl/phy_tx_fifo_arbiter.sv
// ============================================================================
// phy_tx_fifo_arbiter
//
// Grants one PHY-TX FIFO to one of N_REQ byte-stream writers at a time, a whole
// frame at a time. Requesters are served in round-robin order. The owner's byte
// stream reaches the FIFO through a single register stage. Ownership ends on
// the owner's end-of-frame write. A watchdog closes any frame whose owner stalls
// or drops its request, so the FIFO never holds a partial frame.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  owner-idle cycles (no wren) before the frame is force-terminated
//   TW       watchdog counter width, ceil(log2(TIMEOUT+1))
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req          per-requester frame request (level, held until the last byte)
//   req_din      byte data, requester i on bits [8i+7:8i]
//   req_del      end-of-frame flag, qualified by req_wren
//   req_wren     byte write strobe
//   gnt          one-hot ownership grant (registered)
//   req_afull    per-requester backpressure (combinational)
//   fifo_din     byte to the PHY-TX FIFO
//   fifo_del     end-of-frame marker to the PHY-TX FIFO
//   fifo_wren    write strobe to the PHY-TX FIFO
//   fifo_afull   almost-full from the PHY-TX FIFO
//   err_timeout  sticky: a frame was force-terminated
//   err_stray    sticky: a non-granted requester strobed wren
//   err_clr      clears both sticky flags
// ============================================================================
module phy_tx_fifo_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_din,
    input  logic [N_REQ-1:0]     req_del,
    input  logic [N_REQ-1:0]     req_wren,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     req_afull,
    output logic [7:0]           fifo_din,
    output logic                 fifo_del,
    output logic                 fifo_wren,
    input  logic                 fifo_afull,
    output logic                 err_timeout,
    output logic                 err_stray,
    input  logic                 err_clr
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_TERM,
        S_GAP
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t              state_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [IW-1:0]       owner_q;
    logic [IW-1:0]       ptr_q;
    logic [TW-1:0]       wdog_q;
    logic                wrote_q;      // at least one byte of the frame reached the FIFO
    logic [7:0]          fifo_din_q;
    logic                fifo_del_q;
    logic                fifo_wren_q;
    logic                err_timeout_q;
    logic                err_stray_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [IW-1:0]       pick_idx;
    logic                pick_vld;
    logic                own_req;
    logic                own_wren;
    logic                own_del;
    logic [7:0]          own_din;
    logic [TW-1:0]       wdog_inc;
    logic                wdog_expired;
    logic                stray;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == N_REQ - 1)
            return '0;
        else
            return i + IW'(1);
    endfunction

    // Round-robin scan starting at ptr_q; only registered state and req feed it,
    // and its result lands in gnt_q, so there is no combinational req->gnt path.
    always_comb begin
        int cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_REQ)
                cand = cand - N_REQ;
            if (!pick_vld && req[IW'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(cand);
            end
        end
    end

    // Owner's lane of the write interface; other lanes never reach the FIFO.
    always_comb begin
        own_req  = req[owner_q];
        own_wren = req_wren[owner_q];
        own_del  = req_del[owner_q];
        own_din  = req_din[{owner_q, 3'b000} +: 8];
    end

    assign wdog_inc     = wdog_q + TW'(1);
    assign wdog_expired = (wdog_inc == TW'(TIMEOUT));

    // Any strobe outside the grant is an error; the byte is simply not muxed.
    assign stray = |(req_wren & ~gnt_q);

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            owner_q       <= '0;
            ptr_q         <= '0;
            wdog_q        <= '0;
            wrote_q       <= 1'b0;
            fifo_din_q    <= 8'h00;
            fifo_del_q    <= 1'b0;
            fifo_wren_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_stray_q   <= 1'b0;
        end else begin
            // Setting an error wins over a same-cycle clear.
            if (stray)
                err_stray_q <= 1'b1;
            else if (err_clr)
                err_stray_q <= 1'b0;

            if (state_q == S_TERM)
                err_timeout_q <= 1'b1;
            else if (err_clr)
                err_timeout_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    fifo_wren_q <= 1'b0;
                    if (pick_vld && !fifo_afull) begin
                        gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner_q <= pick_idx;
                        wdog_q  <= '0;
                        wrote_q <= 1'b0;
                        state_q <= S_OWN;
                    end
                end

                S_OWN: begin
                    fifo_wren_q <= own_wren;
                    if (own_wren) begin
                        fifo_din_q <= own_din;
                        fifo_del_q <= own_del;
                        wrote_q    <= 1'b1;
                        wdog_q     <= '0;
                    end else begin
                        wdog_q     <= wdog_inc;
                    end

                    // A clean end-of-frame takes priority over any watchdog expiry.
                    if (own_wren && own_del) begin
                        gnt_q   <= '0;
                        ptr_q   <= next_idx(owner_q);
                        state_q <= S_GAP;
                    end else if ((!own_wren && wdog_expired) || !own_req) begin
                        // Drop the grant immediately so the owner is backpressured
                        // while the terminating byte is issued.
                        gnt_q   <= '0;
                        state_q <= S_TERM;
                    end
                end

                S_TERM: begin
                    // Close a runt frame with a zero byte carrying del; a frame
                    // that never started needs no closing write.
                    fifo_wren_q <= wrote_q;
                    if (wrote_q) begin
                        fifo_din_q <= 8'h00;
                        fifo_del_q <= 1'b1;
                    end
                    gnt_q   <= '0;
                    ptr_q   <= next_idx(owner_q);
                    wrote_q <= 1'b0;
                    state_q <= S_GAP;
                end

                S_GAP: begin
                    fifo_wren_q <= 1'b0;
                    state_q     <= S_IDLE;
                end

                default: begin
                    fifo_wren_q <= 1'b0;
                    gnt_q       <= '0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt         = gnt_q;
    assign req_afull   = ~gnt_q | {N_REQ{fifo_afull}};
    assign fifo_din    = fifo_din_q;
    assign fifo_del    = fifo_del_q;
    assign fifo_wren   = fifo_wren_q;
    assign err_timeout = err_timeout_q;
    assign err_stray   = err_stray_q;

endmodule

// File: doc/phy_tx_fifo_arbiter.md
Name: phy_tx_fifo_arbiter

Overview:
Frame-granular mutex for one PHY-TX FIFO, shared by up to N_REQ byte-stream writers (the switch forwarding engine and the control-frame issuer). The block grants ownership of the FIFO write port to one requester at a time, using round-robin order. It muxes that requester's din/del/wren onto the FIFO through one register stage and releases ownership on the end-of-frame write. A watchdog forcibly terminates a stalled or abandoned frame so the FIFO is never left holding a partial frame.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 1024, owner-idle cycles (no wren) before forced termination (>=2)
TW, 11, watchdog counter width, ceil(log2(TIMEOUT+1))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  N_REQ  per-requester frame request; level, held until last byte written
req_din  in  8*N_REQ  byte data; requester i on bits [8i+7:8i]
req_del  in  N_REQ  end-of-frame flag, qualified by req_wren
req_wren  in  N_REQ  byte write strobe
gnt  out  N_REQ  one-hot ownership grant (registered)
req_afull  out  N_REQ  per-requester backpressure
fifo_din  out  8  to PHY-TX FIFO
fifo_del  out  1  to PHY-TX FIFO, end-of-frame marker
fifo_wren  out  1  to PHY-TX FIFO
fifo_afull  in  1  from PHY-TX FIFO
err_timeout  out  1  sticky: a frame was force-terminated
err_stray  out  1  sticky: wren seen from a non-granted requester
err_clr  in  1  clears both sticky flags

Behaviour:
- Reset (rst sampled high at a clk edge): state=IDLE, gnt=0, fifo_din=0, fifo_del=0, fifo_wren=0, priority pointer=0, watchdog=0, err_*=0. Reset mid-frame discards the frame with no terminating write; downstream FIFO is reset by the same rst.
- req_afull[i] = ~gnt[i] | fifo_afull (combinational). Requesters write only while gnt[i]=1 and req_afull[i]=0.
- States:
  - IDLE: if any req and fifo_afull=0, pick the first set req scanning from pointer upward (mod N_REQ) -> gnt one-hot next cycle, go OWN, watchdog=0. Otherwise stay in IDLE.
  - OWN: each cycle the owner's wren/din/del are registered onto fifo_* (1-cycle latency; non-owner inputs never reach the FIFO). Watchdog clears on owner wren, else increments.
    - Owner wren&del -> gnt=0, pointer=owner+1 mod N_REQ, go GAP.
    - Watchdog reaches TIMEOUT, or owner req drops without a del write -> go TERM.
  - TERM: one cycle; fifo_wren=1, fifo_del=1, fifo_din=8'h00 (closes a runt frame). gnt=0, err_timeout=1, pointer=owner+1, go GAP. If TERM is entered before any byte of the frame was written, no terminating write is made; only err_timeout is set.
  - GAP: one dead cycle, fifo_wren=0, then IDLE. Guarantees at least 2 cycles between back-to-back grants.
- fifo_wren is 0 in IDLE and GAP. fifo_din/fifo_del hold their last value when wren=0.
- The FIFO guarantees space for one in-flight byte after afull rises. The arbiter does not re-check afull mid-frame; the requester honours req_afull.
- Simultaneous owner wren&del with timeout expiry: the del path wins, no error.
- err_stray sets on any req_wren[i] with gnt[i]=0; the write is dropped. Error set has priority over a same-cycle err_clr.
- Grant decision uses only registered state plus req/fifo_afull. No combinational path from req to gnt.

Test Plan:
1. Single requester 1, 64-byte frame 0x00..0x3F with del on last byte -> gnt=4'b0010 one cycle after req; FIFO receives the same 64 bytes, del only on 0x3F, each 1 cycle after its req_wren; gnt drops after del.
2. All four req high from reset, each sends 4 bytes -> grant order 0,1,2,3,0; at least 2 cycles between the last FIFO byte of one frame and the next gnt; no interleaved bytes.
3. fifo_afull=1 while req[2] rises -> no grant; afull drops -> gnt[2] next cycle. Mid-frame afull -> req_afull[2]=1, requester pauses, byte stream stays contiguous in order.
4. TIMEOUT=16: owner writes 3 bytes then stalls -> after 16 idle cycles FIFO gets 0x00 with del=1, err_timeout=1, next requester granted. err_clr clears the flag.
5. Requester 3 writes while requester 0 owns -> byte absent at FIFO, err_stray=1, owner frame intact.
6. rst asserted mid-frame -> next cycle gnt=0, fifo_wren=0, pointer=0; fresh req[1] is granted normally.
